frv_mem_arbiter: RTL and testbench

- Shares one downstream memory port between the core's instruction (imem) and data (dmem) requesters.
- Both upstream ports and the downstream port use the core memory protocol:
  - request channel: req/gnt, a transfer occurs when req&&gnt;
  - response channel: recv/ack, a transfer occurs when recv&&ack.
- Sits between the core top level and a single-ported memory/interconnect.
- Arbitrates round-robin, locks the selection while a request is stalled, and routes in-order responses back using an owner FIFO.

---
 rtl/frv_mem_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_frv_mem_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frv_mem_arbiter.sv
// Round-robin arbiter sharing one downstream memory port between the imem and dmem requesters.
// Selection locks while a request stalls; an owner FIFO routes in-order responses back.
module frv_mem_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned DMEM_FIRST      = 1
) (
  input  logic        g_clk,
  input  logic        g_resetn,

  input  logic        imem_req,
  input  logic        imem_wen,
  input  logic [3:0]  imem_strb,
  input  logic [31:0] imem_wdata,
  input  logic [31:0] imem_addr,
  output logic        imem_gnt,
  output logic        imem_recv,
  input  logic        imem_ack,
  output logic        imem_error,
  output logic [31:0] imem_rdata,

  input  logic        dmem_req,
  input  logic        dmem_wen,
  input  logic [3:0]  dmem_strb,
  input  logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_addr,
  output logic        dmem_gnt,
  output logic        dmem_recv,
  input  logic        dmem_ack,
  output logic        dmem_error,
  output logic [31:0] dmem_rdata,

  output logic        mem_req,
  output logic        mem_wen,
  output logic [3:0]  mem_strb,
  output logic [31:0] mem_wdata,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_recv,
  output logic        mem_ack,
  input  logic        mem_error,
  input  logic [31:0] mem_rdata,

  output logic        arb_fault
);

  localparam logic OwnImem = 1'b0;
  localparam logic OwnDmem = 1'b1;
  localparam logic LastGrantRst = (DMEM_FIRST != 0) ? OwnImem : OwnDmem;

  logic [3:0] owner_q, owner_d;
  logic [1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0] count_q, count_d;
  logic       lock_q, lock_d;
  logic       lock_owner_q, lock_owner_d;
  logic       last_grant_q, last_grant_d;

  logic win, sel_req, full, empty, head, push, pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'(MAX_OUTSTANDING - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  assign full  = (count_q == 3'(MAX_OUTSTANDING));
  assign empty = (count_q == 3'd0);
  assign head  = owner_q[rd_ptr_q];

  // Winner selection: frozen to the stalled requester, otherwise round-robin on contention.
  always_comb begin
    win = OwnImem;
    if (lock_q) begin
      win = lock_owner_q;
    end else if (imem_req && dmem_req) begin
      win = ~last_grant_q;
    end else if (dmem_req) begin
      win = OwnDmem;
    end
    sel_req = (win == OwnDmem) ? dmem_req : imem_req;
  end

  // Request channel
  always_comb begin
    mem_req   = sel_req && !full;
    mem_wen   = 1'b0;
    mem_strb  = 4'd0;
    mem_wdata = 32'd0;
    mem_addr  = 32'd0;
    if (mem_req) begin
      if (win == OwnDmem) begin
        mem_wen   = dmem_wen;
        mem_strb  = dmem_strb;
        mem_wdata = dmem_wdata;
        mem_addr  = dmem_addr;
      end else begin
        mem_wen   = imem_wen;
        mem_strb  = imem_strb;
        mem_wdata = imem_wdata;
        mem_addr  = imem_addr;
      end
    end
    imem_gnt = mem_req && mem_gnt && (win == OwnImem);
    dmem_gnt = mem_req && mem_gnt && (win == OwnDmem);
  end

  // Response channel: an unowned response is drained and flagged.
  always_comb begin
    imem_recv  = 1'b0;
    imem_error = 1'b0;
    imem_rdata = 32'd0;
    dmem_recv  = 1'b0;
    dmem_error = 1'b0;
    dmem_rdata = 32'd0;
    mem_ack    = 1'b0;
    arb_fault  = 1'b0;
    if (empty) begin
      mem_ack   = mem_recv;
      arb_fault = mem_recv;
    end else if (head == OwnDmem) begin
      dmem_recv  = mem_recv;
      dmem_error = mem_error;
      dmem_rdata = mem_rdata;
      mem_ack    = dmem_ack;
    end else begin
      imem_recv  = mem_recv;
      imem_error = mem_error;
      imem_rdata = mem_rdata;
      mem_ack    = imem_ack;
    end
  end

  always_comb begin
    push         = mem_req && mem_gnt;
    pop          = !empty && mem_recv && mem_ack;
    owner_d      = owner_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    lock_d       = lock_q;
    lock_owner_d = lock_owner_q;
    last_grant_d = last_grant_q;
    if (push) begin
      owner_d[wr_ptr_q] = win;
      wr_ptr_d          = ptr_inc(wr_ptr_q);
      last_grant_d      = win;
      lock_d            = 1'b0;
    end else if (mem_req) begin
      lock_d       = 1'b1;
      lock_owner_d = win;
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (push && !pop) begin
      count_d = count_q + 3'd1;
    end else if (pop && !push) begin
      count_d = count_q - 3'd1;
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      owner_q      <= 4'd0;
      wr_ptr_q     <= 2'd0;
      rd_ptr_q     <= 2'd0;
      count_q      <= 3'd0;
      lock_q       <= 1'b0;
      lock_owner_q <= OwnImem;
      last_grant_q <= LastGrantRst;
    end else begin
      owner_q      <= owner_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      lock_q       <= lock_d;
      lock_owner_q <= lock_owner_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: tb/tb_frv_mem_arbiter.sv
// Directed self-checking bench for frv_mem_arbiter (MAX_OUTSTANDING=2, DMEM_FIRST=1).
module tb_frv_mem_arbiter;

  logic        g_clk = 1'b0;
  logic        g_resetn;
  logic        imem_req, imem_wen, imem_gnt, imem_recv, imem_ack, imem_error;
  logic [3:0]  imem_strb;
  logic [31:0] imem_wdata, imem_addr, imem_rdata;
  logic        dmem_req, dmem_wen, dmem_gnt, dmem_recv, dmem_ack, dmem_error;
  logic [3:0]  dmem_strb;
  logic [31:0] dmem_wdata, dmem_addr, dmem_rdata;
  logic        mem_req, mem_wen, mem_gnt, mem_recv, mem_ack, mem_error;
  logic [3:0]  mem_strb;
  logic [31:0] mem_wdata, mem_addr, mem_rdata;
  logic        arb_fault;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 g_clk = ~g_clk;

  frv_mem_arbiter #(
    .MAX_OUTSTANDING(2),
    .DMEM_FIRST     (1)
  ) u_dut (
    .g_clk     (g_clk),
    .g_resetn  (g_resetn),
    .imem_req  (imem_req),
    .imem_wen  (imem_wen),
    .imem_strb (imem_strb),
    .imem_wdata(imem_wdata),
    .imem_addr (imem_addr),
    .imem_gnt  (imem_gnt),
    .imem_recv (imem_recv),
    .imem_ack  (imem_ack),
    .imem_error(imem_error),
    .imem_rdata(imem_rdata),
    .dmem_req  (dmem_req),
    .dmem_wen  (dmem_wen),
    .dmem_strb (dmem_strb),
    .dmem_wdata(dmem_wdata),
    .dmem_addr (dmem_addr),
    .dmem_gnt  (dmem_gnt),
    .dmem_recv (dmem_recv),
    .dmem_ack  (dmem_ack),
    .dmem_error(dmem_error),
    .dmem_rdata(dmem_rdata),
    .mem_req   (mem_req),
    .mem_wen   (mem_wen),
    .mem_strb  (mem_strb),
    .mem_wdata (mem_wdata),
    .mem_addr  (mem_addr),
    .mem_gnt   (mem_gnt),
    .mem_recv  (mem_recv),
    .mem_ack   (mem_ack),
    .mem_error (mem_error),
    .mem_rdata (mem_rdata),
    .arb_fault (arb_fault)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_idle();
    imem_req = 0; imem_wen = 0; imem_strb = 4'h0; imem_wdata = 0; imem_addr = 32'h1000;
    dmem_req = 0; dmem_wen = 0; dmem_strb = 4'hf; dmem_wdata = 32'hdead_beef;
    dmem_addr = 32'h2000;
    imem_ack = 1; dmem_ack = 1;
    mem_gnt = 0; mem_recv = 0; mem_error = 0; mem_rdata = 0;
  endtask

  initial begin
    drive_idle();
    g_resetn = 0;
    settle();
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_gnt", {30'd0, dmem_gnt, imem_gnt}, 0);
    check("rst_mem_ack", 32'(mem_ack), 0);
    check("rst_fault", 32'(arb_fault), 0);
    tick(); tick();
    g_resetn = 1;
    tick();

    // Single imem read
    imem_req = 1; imem_addr = 32'h8000_0000; mem_gnt = 1;
    settle();
    check("rd_mem_addr", mem_addr, 32'h8000_0000);
    check("rd_imem_gnt", 32'(imem_gnt), 1);
    check("rd_dmem_gnt", 32'(dmem_gnt), 0);
    tick();
    imem_req = 0; mem_gnt = 0; mem_recv = 1; mem_rdata = 32'h0000_0013;
    settle();
    check("rd_imem_recv", 32'(imem_recv), 1);
    check("rd_imem_rdata", imem_rdata, 32'h0000_0013);
    check("rd_dmem_recv", 32'(dmem_recv), 0);
    check("rd_mem_ack", 32'(mem_ack), 1);
    tick();
    drive_idle();

    // Contention with immediate responses: dmem, imem, dmem, imem
    imem_req = 1; dmem_req = 1; mem_gnt = 1;
    for (int i = 0; i < 4; i++) begin
      mem_recv = (i != 0);
      settle();
      check("rr_gnt", {30'd0, dmem_gnt, imem_gnt}, (i % 2 == 0) ? 2 : 1);
      check("rr_addr", mem_addr, (i % 2 == 0) ? 32'h2000 : 32'h1000);
      if (i != 0) begin
        check("rr_resp", {30'd0, dmem_recv, imem_recv}, (i % 2 == 0) ? 1 : 2);
      end
      tick();
    end
    imem_req = 0; dmem_req = 0; mem_gnt = 0; mem_recv = 1;
    settle();
    check("rr_last_resp", {30'd0, dmem_recv, imem_recv}, 1);
    tick();
    drive_idle();

    // Stall with both requesting: dmem wins and holds the port
    imem_req = 1; dmem_req = 1;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("stall_addr", mem_addr, 32'h2000);
      check("stall_gnt", {30'd0, dmem_gnt, imem_gnt}, 0);
      tick();
    end
    mem_gnt = 1;
    settle();
    check("stall_rel_gnt", {30'd0, dmem_gnt, imem_gnt}, 2);
    tick();
    dmem_req = 0;
    settle();
    check("stall_next_gnt", {30'd0, dmem_gnt, imem_gnt}, 1);
    check("stall_next_addr", mem_addr, 32'h1000);
    tick();
    imem_req = 0; mem_gnt = 0; mem_recv = 1;
    settle();
    check("stall_resp0", {30'd0, dmem_recv, imem_recv}, 2);
    tick();
    settle();
    check("stall_resp1", {30'd0, dmem_recv, imem_recv}, 1);
    tick();
    drive_idle();

    // Lock holds imem even though dmem would win round-robin once it joins
    imem_req = 1;
    settle();
    check("lock_addr0", mem_addr, 32'h1000);
    tick();
    dmem_req = 1;
    settle();
    check("lock_addr1", mem_addr, 32'h1000);
    mem_gnt = 1;
    settle();
    check("lock_gnt", {30'd0, dmem_gnt, imem_gnt}, 1);
    tick();
    imem_req = 0;
    settle();
    check("lock_after_gnt", {30'd0, dmem_gnt, imem_gnt}, 2);
    tick();
    dmem_req = 0; mem_gnt = 0; mem_recv = 1;
    tick(); tick();
    drive_idle();

    // Outstanding limit of two
    dmem_req = 1; mem_gnt = 1; dmem_addr = 32'h3000;
    settle();
    check("lim_gnt0", 32'(dmem_gnt), 1);
    tick();
    dmem_addr = 32'h3004;
    settle();
    check("lim_gnt1", 32'(dmem_gnt), 1);
    tick();
    dmem_addr = 32'h3008;
    settle();
    check("lim_full_req", 32'(mem_req), 0);
    check("lim_full_gnt", 32'(dmem_gnt), 0);
    tick();
    mem_recv = 1;
    settle();
    check("lim_pop_recv", 32'(dmem_recv), 1);
    check("lim_pop_ack", 32'(mem_ack), 1);
    check("lim_pop_gnt", 32'(dmem_gnt), 0);
    tick();
    mem_recv = 0;
    settle();
    check("lim_third_gnt", 32'(dmem_gnt), 1);
    check("lim_third_addr", mem_addr, 32'h3008);
    tick();
    dmem_req = 0; mem_gnt = 0; mem_recv = 1;
    tick(); tick();
    drive_idle();

    // Ordered routing with a back-pressured imem response
    imem_req = 1; mem_gnt = 1;
    tick();
    imem_req = 0; dmem_req = 1;
    tick();
    dmem_req = 0; mem_gnt = 0;
    mem_recv = 1; mem_rdata = 32'h11; imem_ack = 0;
    for (int i = 0; i < 2; i++) begin
      settle();
      check("ord_hold_recv", 32'(imem_recv), 1);
      check("ord_hold_ack", 32'(mem_ack), 0);
      check("ord_hold_dmem", 32'(dmem_recv), 0);
      tick();
    end
    imem_ack = 1;
    settle();
    check("ord_a_rdata", imem_rdata, 32'h11);
    check("ord_a_err", 32'(imem_error), 0);
    check("ord_a_ack", 32'(mem_ack), 1);
    tick();
    mem_rdata = 32'h22; mem_error = 1;
    settle();
    check("ord_b_recv", 32'(dmem_recv), 1);
    check("ord_b_rdata", dmem_rdata, 32'h22);
    check("ord_b_err", 32'(dmem_error), 1);
    check("ord_b_imem", {30'd0, imem_error, imem_recv}, 0);
    tick();
    drive_idle();

    // Unowned response
    mem_recv = 1;
    settle();
    check("flt_ack", 32'(mem_ack), 1);
    check("flt_pulse", 32'(arb_fault), 1);
    check("flt_up_recv", {30'd0, dmem_recv, imem_recv}, 0);
    tick();
    mem_recv = 0;
    settle();
    check("flt_clear", 32'(arb_fault), 0);
    tick();

    // Asynchronous reset with two outstanding
    imem_req = 1; mem_gnt = 1;
    tick();
    imem_req = 0; dmem_req = 1;
    tick();
    dmem_req = 0; mem_gnt = 0;
    #1;
    g_resetn = 0;
    settle();
    check("arst_fault", 32'(arb_fault), 0);
    tick();
    g_resetn = 1;
    mem_recv = 1;
    settle();
    check("arst_late_fault", 32'(arb_fault), 1);
    check("arst_late_ack", 32'(mem_ack), 1);
    check("arst_late_up", {30'd0, dmem_recv, imem_recv}, 0);
    tick();
    mem_recv = 0; imem_req = 1; dmem_req = 1; mem_gnt = 1;
    settle();
    check("arst_first_win", {30'd0, dmem_gnt, imem_gnt}, 2);
    tick();
    dmem_req = 0;
    settle();
    check("arst_second_gnt", {30'd0, dmem_gnt, imem_gnt}, 1);
    tick();
    drive_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
